// File: rtl/hex_scroll_pkg.sv
// Shared types and segment constants for the
// scrolling hex display controller.
package hex_scroll_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STATIC,
    SCROLL,
    PAUSE
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b0100111;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/hex_scroll_ctrl_dec.sv
// Nibble to active-low 7-segment decoder,
// segment order {g,f,e,d,c,b,a}.
module hex_digit_dec
  import hex_scroll_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (1'b1)
      (nib == 4'h0): seg = SEG_0;
      (nib == 4'h1): seg = SEG_1;
      (nib == 4'h2): seg = SEG_2;
      (nib == 4'h3): seg = SEG_3;
      (nib == 4'h4): seg = SEG_4;
      (nib == 4'h5): seg = SEG_5;
      (nib == 4'h6): seg = SEG_6;
      (nib == 4'h7): seg = SEG_7;
      (nib == 4'h8): seg = SEG_8;
      (nib == 4'h9): seg = SEG_9;
      (nib == 4'hA): seg = SEG_A;
      (nib == 4'hB): seg = SEG_B;
      (nib == 4'hC): seg = SEG_C;
      (nib == 4'hD): seg = SEG_D;
      (nib == 4'hE): seg = SEG_E;
      (nib == 4'hF): seg = SEG_F;
      default:       seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hex_scroll_ctrl.sv
// Message buffer plus scrolling 8-digit window
// driving HEX7..HEX0 through registered outputs.
module hex_scroll_ctrl
  import hex_scroll_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000,
  parameter int DEPTH    = 16
) (
  input  logic                   CLOCK_50,
  input  logic                   RST_N,
  input  logic                   clr,
  input  logic                   wr_en,
  input  logic [3:0]             wr_data,
  input  logic                   run,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic [6:0]             HEX7,
  output logic [6:0]             HEX6,
  output logic [6:0]             HEX5,
  output logic [6:0]             HEX4,
  output logic [6:0]             HEX3,
  output logic [6:0]             HEX2,
  output logic [6:0]             HEX1,
  output logic [6:0]             HEX0
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] PRE_MAX =
    TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  state_t        state;
  state_t        state_nx;
  logic [3:0]    msg [DEPTH];
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nx;
  logic [TW-1:0] pre;
  logic [TW-1:0] pre_nx;
  logic [CW-1:0] cnt_nx;
  logic          wr_ok;
  logic [6:0]    hex_q  [8];
  logic [6:0]    hex_nx [8];

  assign wr_ok = wr_en && !clr && !full;

  always_comb begin
    cnt_nx = count;
    if (clr)
      cnt_nx = '0;
    else if (wr_ok)
      cnt_nx = count + CW'(1);
  end

  always_comb begin
    if (cnt_nx == '0)
      state_nx = IDLE;
    else if (cnt_nx < CW'(8))
      state_nx = STATIC;
    else if (run)
      state_nx = SCROLL;
    else
      state_nx = PAUSE;
  end

  // wrap compares against the pre-write count
  always_comb begin
    ptr_nx = '0;
    pre_nx = '0;
    if (!clr && state == PAUSE) begin
      ptr_nx = ptr;
      pre_nx = pre;
    end else if (!clr && state == SCROLL) begin
      ptr_nx = ptr;
      pre_nx = pre + TW'(1);
      if (pre == PRE_MAX) begin
        pre_nx = '0;
        if ({1'b0, ptr} + CW'(1) == count)
          ptr_nx = '0;
        else
          ptr_nx = ptr + PW'(1);
      end
    end
  end

  for (genvar k = 0; k < 8; k++) begin : g_dig
    logic [CW-1:0] sum;
    logic [CW-1:0] idx;
    logic [3:0]    nib;
    logic [6:0]    seg;

    assign sum = {1'b0, ptr} + CW'(k);
    assign idx = (sum >= count) ? sum - count : sum;
    assign nib = msg[idx[PW-1:0]];

    hex_digit_dec u_dec (
      .nib (nib),
      .seg (seg)
    );

    assign hex_nx[k] =
      (CW'(k) < count) ? seg : SEG_BLANK;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RST_N) begin
      state <= IDLE;
      count <= '0;
      full  <= 1'b0;
      ptr   <= '0;
      pre   <= '0;
      for (int k = 0; k < 8; k++)
        hex_q[k] <= SEG_BLANK;
    end else begin
      state <= state_nx;
      count <= cnt_nx;
      full  <= (cnt_nx == CNT_MAX);
      ptr   <= ptr_nx;
      pre   <= pre_nx;
      for (int k = 0; k < 8; k++)
        hex_q[k] <= hex_nx[k];
      if (wr_ok)
        msg[count[PW-1:0]] <= wr_data;
    end
  end

  assign HEX7 = hex_q[0];
  assign HEX6 = hex_q[1];
  assign HEX5 = hex_q[2];
  assign HEX4 = hex_q[3];
  assign HEX3 = hex_q[4];
  assign HEX2 = hex_q[5];
  assign HEX1 = hex_q[6];
  assign HEX0 = hex_q[7];

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Directed checks for hex_scroll_ctrl with
// TICK_DIV=4, DEPTH=16.
module tb_hex_scroll_ctrl;

  localparam int TD = 4;
  localparam int DP = 16;
  localparam int B  = -1;
  localparam logic [6:0] BL = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_data = 4'h0;
  logic       run = 1'b0;
  logic       full;
  logic [4:0] count;
  logic [6:0] h7, h6, h5, h4, h3, h2, h1, h0;
  logic [55:0] hexv;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign hexv = {h7, h6, h5, h4, h3, h2, h1, h0};

  hex_scroll_ctrl #(
    .TICK_DIV (TD),
    .DEPTH    (DP)
  ) dut (
    .CLOCK_50 (clk),
    .RST_N    (rst_n),
    .clr      (clr),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .run      (run),
    .full     (full),
    .count    (count),
    .HEX7     (h7),
    .HEX6     (h6),
    .HEX5     (h5),
    .HEX4     (h4),
    .HEX3     (h3),
    .HEX2     (h2),
    .HEX1     (h1),
    .HEX0     (h0)
  );

  typedef struct {
    logic        c;
    logic        w;
    logic [3:0]  d;
    logic        r;
    logic [4:0]  cnt;
    logic        fl;
    logic [55:0] hx;
  } vec_t;

  vec_t tv [7];

  function automatic logic [6:0] seg(
    input logic [3:0] n
  );
    logic [6:0] t [16];
    t = '{7'b1000000, 7'b1111001, 7'b0100100,
          7'b0110000, 7'b0011001, 7'b0010010,
          7'b0000010, 7'b1111000, 7'b0000000,
          7'b0010000, 7'b0001000, 7'b0000011,
          7'b0100111, 7'b0100001, 7'b0000110,
          7'b0001110};
    return t[n];
  endfunction

  function automatic logic [55:0] disp(
    input int d7, d6, d5, d4,
    input int d3, d2, d1, d0
  );
    int d [8];
    logic [55:0] r;
    d = '{d7, d6, d5, d4, d3, d2, d1, d0};
    r = '0;
    for (int i = 0; i < 8; i++)
      r[55-7*i -: 7] =
        (d[i] < 0) ? BL : seg(4'(d[i]));
    return r;
  endfunction

  function automatic vec_t mkv(
    input logic c, w,
    input logic [3:0] d,
    input logic r,
    input logic [4:0] cnt,
    input logic fl,
    input logic [55:0] hx
  );
    vec_t v;
    v.c = c; v.w = w; v.d = d; v.r = r;
    v.cnt = cnt; v.fl = fl; v.hx = hx;
    return v;
  endfunction

  task automatic chk(
    input string nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr = 1'b0;
    wr_en = 1'b0;
    run = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic wr(input logic [3:0] d);
    wr_en = 1'b1;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_h7(output int n);
    logic [6:0] prev;
    prev = h7;
    n = 0;
    do begin
      tick();
      n++;
    end while (h7 == prev && n < 12);
  endtask

  int n;
  logic bad;
  logic [55:0] snap;

  initial begin
    tv[0] = mkv(0, 1, 4'h1, 0, 5'd1, 0,
                disp(B, B, B, B, B, B, B, B));
    tv[1] = mkv(0, 1, 4'h2, 0, 5'd2, 0,
                disp(1, B, B, B, B, B, B, B));
    tv[2] = mkv(0, 1, 4'h3, 0, 5'd3, 0,
                disp(1, 2, B, B, B, B, B, B));
    tv[3] = mkv(0, 0, 4'h0, 1, 5'd3, 0,
                disp(1, 2, 3, B, B, B, B, B));
    tv[4] = mkv(0, 0, 4'h0, 1, 5'd3, 0,
                disp(1, 2, 3, B, B, B, B, B));
    tv[5] = mkv(1, 1, 4'h5, 1, 5'd0, 0,
                disp(1, 2, 3, B, B, B, B, B));
    tv[6] = mkv(0, 0, 4'h0, 1, 5'd0, 0,
                disp(B, B, B, B, B, B, B, B));

    // reset
    rst_n = 1'b0;
    tick(2);
    chk("rst_hex", hexv, {8{BL}});
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    rst_n = 1'b1;
    run = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (hexv !== {8{BL}}) bad = 1'b1;
    end
    chk("idle_run_blank", bad, 0);
    run = 1'b0;

    // static table, with a hold gap before clr
    for (int i = 0; i < 7; i++) begin
      if (i == 5) begin
        snap = hexv;
        bad = 1'b0;
        run = 1'b1;
        for (int j = 0; j < 20; j++) begin
          tick();
          if (hexv !== snap) bad = 1'b1;
        end
        chk("static_hold", bad, 0);
      end
      clr = tv[i].c;
      wr_en = tv[i].w;
      wr_data = tv[i].d;
      run = tv[i].r;
      tick();
      chk($sformatf("tv%0d_count", i),
          count, tv[i].cnt);
      chk($sformatf("tv%0d_full", i),
          full, tv[i].fl);
      chk($sformatf("tv%0d_hex", i),
          hexv, tv[i].hx);
    end
    clr = 1'b0;
    wr_en = 1'b0;

    // scroll with wrap
    do_reset();
    for (int i = 0; i < 10; i++) begin
      wr(4'(i));
      if (i == 7) begin
        tick();
        chk("cnt8_hex", hexv,
            disp(0, 1, 2, 3, 4, 5, 6, 7));
      end
    end
    tick();
    chk("cnt10_count", count, 10);
    chk("pause0_hex", hexv,
        disp(0, 1, 2, 3, 4, 5, 6, 7));
    run = 1'b1;
    wait_h7(n);
    chk("first_step_lat", n, 6);
    chk("step1_h7", h7, seg(4'h1));
    for (int s = 2; s <= 10; s++) begin
      wait_h7(n);
      chk($sformatf("step%0d_gap", s), n, TD);
      chk($sformatf("step%0d_h7", s),
          h7, seg(4'(s % 10)));
      if (s == 9)
        chk("ptr9_hex", hexv,
            disp(9, 0, 1, 2, 3, 4, 5, 6));
    end

    // pause at pre=2, then resume
    tick();
    run = 1'b0;
    snap = hexv;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (hexv !== snap) bad = 1'b1;
    end
    chk("pause_hold", bad, 0);
    run = 1'b1;
    wait_h7(n);
    chk("resume_lat", n, 3);
    chk("resume_h7", h7, seg(4'h1));

    // fill to full and overflow
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      wr(4'hF);
      if (i >= 15) begin
        chk($sformatf("fill%0d_count", i),
            count, (i > 16) ? 16 : i);
        chk($sformatf("fill%0d_full", i),
            full, (i >= 16) ? 1 : 0);
      end
    end
    tick();
    chk("full_hex", hexv,
        disp(15, 15, 15, 15, 15, 15, 15, 15));

    // clr beats wr_en while scrolling
    run = 1'b1;
    tick(5);
    clr = 1'b1;
    wr_en = 1'b1;
    wr_data = 4'h3;
    tick();
    clr = 1'b0;
    wr_en = 1'b0;
    chk("clr_count", count, 0);
    chk("clr_full", full, 0);
    tick();
    chk("clr_hex", hexv, {8{BL}});
    wr(4'h7);
    chk("post_clr_count", count, 1);
    tick();
    chk("post_clr_hex", hexv,
        disp(7, B, B, B, B, B, B, B));

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
